// File: rtl/lsu_pkg.sv
// Shared size codes, FSM state encoding and helpers for the load/store memory master.
// Optional feature macro used by the top level: LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } lsu_state_t;

  // Size code 2'b11 behaves exactly like a word access.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts/extends load data and merges sub-word store data
// into an existing memory word, little-endian lane order.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [31:0] i_old,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_offset,
  input  logic        i_signed,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Halves only look at offset bit 1 and words ignore the offset, which aligns them implicitly.
  always_comb begin
    case (i_offset)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_offset[1] ? i_rdata[31:16] : i_rdata[15:0];

    if (is_word(i_size)) begin
      o_load = i_rdata;
    end else if (i_size == SZ_HALF) begin
      o_load = {{16{i_signed & w_half[15]}}, w_half};
    end else begin
      o_load = {{24{i_signed & w_byte[7]}}, w_byte};
    end

    o_merge = i_old;
    if (is_word(i_size)) begin
      o_merge = i_wdata;
    end else if (i_size == SZ_HALF) begin
      if (i_offset[1]) o_merge[31:16] = i_wdata[15:0];
      else             o_merge[15:0]  = i_wdata[15:0];
    end else begin
      case (i_offset)
        2'd0:    o_merge[7:0]   = i_wdata[7:0];
        2'd1:    o_merge[15:8]  = i_wdata[7:0];
        2'd2:    o_merge[23:16] = i_wdata[7:0];
        default: o_merge[31:24] = i_wdata[7:0];
      endcase
    end
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store master: turns one byte/half/word core request into word accesses on the data memory.
// Define LSU_MISALIGN_TRAP_EN to raise an error on misaligned half/word accesses instead of aligning them.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_add,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  r_state;
  logic [31:0] r_addr_q;
  logic [31:0] r_wdata_q;
  logic [31:0] r_rdata_q;
  logic [1:0]  r_size_q;
  logic        r_we_q;
  logic        r_signed_q;
  logic        r_resp_valid;
  logic        r_resp_err;
  logic [31:0] r_resp_rdata;
  logic [31:0] r_add_hold;
  logic [31:0] r_wdata_hold;

  logic        w_accept;
  logic        w_range_err;
  logic        w_err;
  logic [31:0] w_load;
  logic [31:0] w_merge;
  logic [31:0] w_mem_add;
  logic [31:0] w_mem_wdata;

  assign w_accept    = req_valid && (r_state == ST_IDLE);
  assign w_range_err = (req_addr[31:2] >= 30'(MEM_WORDS));

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_misalign;
  assign w_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                      (is_word(req_size) && (req_addr[1:0] != 2'b00));
  assign w_err      = w_range_err || w_misalign;
`else
  assign w_err      = w_range_err;
`endif

  lsu_byte_lane u_lane (
    .i_rdata  (mem_rdata),
    .i_old    (r_rdata_q),
    .i_wdata  (r_wdata_q),
    .i_size   (r_size_q),
    .i_offset (r_addr_q[1:0]),
    .i_signed (r_signed_q),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  // Address and write data follow the latched request only while accessing memory, else hold.
  assign w_mem_add   = ((r_state == ST_RD) || (r_state == ST_WR)) ? {2'b00, r_addr_q[31:2]} : r_add_hold;
  assign w_mem_wdata = (r_state == ST_WR) ? w_merge : r_wdata_hold;

  assign mem_add    = w_mem_add;
  assign mem_wdata  = w_mem_wdata;
  assign mem_we     = (r_state == ST_WR);
  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_addr_q     <= '0;
      r_wdata_q    <= '0;
      r_rdata_q    <= '0;
      r_size_q     <= SZ_BYTE;
      r_we_q       <= 1'b0;
      r_signed_q   <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_add_hold   <= '0;
      r_wdata_hold <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_add_hold   <= w_mem_add;
      r_wdata_hold <= w_mem_wdata;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr_q   <= req_addr;
            r_wdata_q  <= req_wdata;
            r_size_q   <= req_size;
            r_we_q     <= req_we;
            r_signed_q <= req_signed;
            if (w_err) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else if (req_we && is_word(req_size)) begin
              r_state <= ST_WR;
            end else begin
              r_state <= ST_RD;
            end
          end
        end
        ST_RD: begin
          r_rdata_q <= mem_rdata;
          if (r_we_q) begin
            r_state <= ST_WR;
          end else begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= w_load;
          end
        end
        ST_WR: begin
          r_state      <= ST_RESP;
          r_resp_valid <= 1'b1;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed vector table, reset-abort sequence,
// and randomized traffic against a shift/mask reference model with a word-array memory.
module tb_lsu_mem_master;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_add;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] tbMem [0:127];
  logic [31:0] refMem [0:99];

  int testsRun  = 0;
  int failCount = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
    int          expLat;
    int          expWe;
    logic [31:0] expAdd;
    logic [31:0] expWdata;
  } vec_t;

  vec_t vecs [16];

  lsu_mem_master #(.MEM_WORDS(100)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_add    (mem_add),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, synchronous write.
  assign mem_rdata = (mem_add < 32'd128) ? tbMem[mem_add[6:0]] : 32'h0;
  always @(posedge clk) begin
    if (mem_we && (mem_add < 32'd128)) tbMem[mem_add[6:0]] <= mem_wdata;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: misaligned accesses trap only in the trapping build.
  function automatic logic refError(input logic [31:0] addr, input logic [1:0] sz);
    logic e;
    e = (addr >> 2) >= 32'd100;
`ifdef LSU_MISALIGN_TRAP_EN
    if ((sz == 2'b01) && addr[0]) e = 1'b1;
    if (sz[1] && (addr[1:0] != 2'b00)) e = 1'b1;
`else
    if (sz == 2'b11) e = e;
`endif
    return e;
  endfunction

  function automatic int refShift(input logic [1:0] sz, input logic [1:0] off);
    if (sz[1]) return 0;
    if (sz == 2'b01) return (int'(off) / 2) * 16;
    return int'(off) * 8;
  endfunction

  function automatic logic [31:0] refExtract(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sgn, input logic [1:0] off);
    logic [31:0] v;
    if (sz[1]) return w;
    v = w >> refShift(sz, off);
    if (sz == 2'b00) begin
      v = v & 32'h0000_00FF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else begin
      v = v & 32'h0000_FFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] refMerge(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] mask;
    int sh;
    if (sz[1]) return wd;
    sh   = refShift(sz, off);
    mask = ((sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic applyStimulus(input logic we, input logic [1:0] sz, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err, output int lat,
                               output int weCnt, output logic [31:0] wAdd,
                               output logic [31:0] wData, output logic timedOut);
    int waitCnt;
    rdata = 32'h0; err = 1'b0; lat = 0; weCnt = 0; wAdd = 32'h0; wData = 32'h0;
    timedOut = 1'b1;
    @(negedge clk);
    waitCnt = 0;
    while (!req_ready && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!req_ready) return;
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      if (mem_we) begin
        weCnt++;
        wAdd  = mem_add;
        wData = mem_wdata;
      end
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; err = resp_err; timedOut = 1'b0;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic runModel(input logic we, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    logic [31:0] r, wa, wd, old, expR, expWd;
    logic e, to, expErr;
    int lat, weCnt, expLat, widx;
    expErr = refError(addr, sz);
    widx   = expErr ? 0 : int'(addr >> 2);
    old    = refMem[widx];
    expLat = expErr ? 1 : (!we ? 2 : (sz[1] ? 2 : 3));
    expR   = (expErr || we) ? 32'h0 : refExtract(old, sz, sgn, addr[1:0]);
    expWd  = refMerge(old, wdata, sz, addr[1:0]);
    applyStimulus(we, sz, sgn, addr, wdata, r, e, lat, weCnt, wa, wd, to);
    checkOutput($sformatf("%s_timeout", tag), 32'(to), 32'h0);
    checkOutput($sformatf("%s_err", tag), 32'(e), 32'(expErr));
    checkOutput($sformatf("%s_rdata", tag), r, expR);
    checkOutput($sformatf("%s_latency", tag), 32'(lat), 32'(expLat));
    checkOutput($sformatf("%s_we_cycles", tag), 32'(weCnt), (we && !expErr) ? 32'd1 : 32'd0);
    if (we && !expErr) begin
      checkOutput($sformatf("%s_mem_add", tag), wa, addr >> 2);
      checkOutput($sformatf("%s_mem_wdata", tag), wd, expWd);
      refMem[widx] = expWd;
    end
  endtask

  initial begin
    logic [31:0] r, wa, wd, a;
    logic e, to, sawResp;
    int lat, weCnt;

    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    #3;
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
    checkOutput("rst_resp_err", 32'(resp_err), 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rst_mem_add", mem_add, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    reset = 1'b1;

    vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h14,  32'h8899AABB, 32'h0,        1'b0, 2, 1, 32'd5,  32'h8899AABB};
    vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h15,  32'h0,        32'hFFFFFFAA, 1'b0, 2, 0, 32'd0,  32'h0};
    vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h17,  32'h0,        32'h00000088, 1'b0, 2, 0, 32'd0,  32'h0};
    vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h14,  32'h0,        32'h8899AABB, 1'b0, 2, 0, 32'd0,  32'h0};
    vecs[4]  = '{1'b1, 2'b01, 1'b0, 32'h16,  32'h00001234, 32'h0,        1'b0, 3, 1, 32'd5,  32'h1234AABB};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 32'h16,  32'h0,        32'h00001234, 1'b0, 2, 0, 32'd0,  32'h0};
    vecs[6]  = '{1'b0, 2'b10, 1'b0, 32'h190, 32'h0,        32'h0,        1'b1, 1, 0, 32'd0,  32'h0};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h15,  32'h0,        32'h0,        1'b1, 1, 0, 32'd0,  32'h0};
`else
    vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h15,  32'h0,        32'h1234AABB, 1'b0, 2, 0, 32'd0,  32'h0};
`endif
    vecs[8]  = '{1'b1, 2'b10, 1'b0, 32'h18C, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'd99, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 2'b01, 1'b0, 32'h18E, 32'h0,        32'h0000DEAD, 1'b0, 2, 0, 32'd0,  32'h0};
    vecs[10] = '{1'b0, 2'b01, 1'b1, 32'h18C, 32'h0,        32'hFFFFBEEF, 1'b0, 2, 0, 32'd0,  32'h0};
    vecs[11] = '{1'b1, 2'b00, 1'b0, 32'h18F, 32'h0000017F, 32'h0,        1'b0, 3, 1, 32'd99, 32'h7FADBEEF};
    vecs[12] = '{1'b0, 2'b11, 1'b0, 32'h18C, 32'h0,        32'h7FADBEEF, 1'b0, 2, 0, 32'd0,  32'h0};
    vecs[13] = '{1'b1, 2'b10, 1'b0, 32'h190, 32'h11111111, 32'h0,        1'b1, 1, 0, 32'd0,  32'h0};
    vecs[14] = '{1'b0, 2'b00, 1'b1, 32'h18F, 32'h0,        32'h0000007F, 1'b0, 2, 0, 32'd0,  32'h0};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[15] = '{1'b0, 2'b01, 1'b0, 32'h18D, 32'h0,        32'h0,        1'b1, 1, 0, 32'd0,  32'h0};
`else
    vecs[15] = '{1'b0, 2'b01, 1'b0, 32'h18D, 32'h0,        32'h0000BEEF, 1'b0, 2, 0, 32'd0,  32'h0};
`endif

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                    r, e, lat, weCnt, wa, wd, to);
      checkOutput($sformatf("vec%0d_timeout", i), 32'(to), 32'h0);
      checkOutput($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].expErr));
      checkOutput($sformatf("vec%0d_rdata", i), r, vecs[i].expRdata);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].expLat));
      checkOutput($sformatf("vec%0d_we_cycles", i), 32'(weCnt), 32'(vecs[i].expWe));
      if (vecs[i].expWe != 0) begin
        checkOutput($sformatf("vec%0d_mem_add", i), wa, vecs[i].expAdd);
        checkOutput($sformatf("vec%0d_mem_wdata", i), wd, vecs[i].expWdata);
      end
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_resp_pulse", i), 32'(resp_valid), 32'h0);
      checkOutput($sformatf("vec%0d_ready_back", i), 32'(req_ready), 32'h1);
    end

    // Abort a sub-word store in its write cycle with an asynchronous reset.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0;
    req_addr = 32'h16; req_wdata = 32'h00005555;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("abort_busy_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("abort_wr_mem_we", 32'(mem_we), 32'h1);
    reset = 1'b0;
    #1;
    checkOutput("abort_mem_we_drop", 32'(mem_we), 32'h0);
    checkOutput("abort_ready", 32'(req_ready), 32'h1);
    checkOutput("abort_resp_valid", 32'(resp_valid), 32'h0);
    sawResp = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      if (resp_valid) sawResp = 1'b1;
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      if (resp_valid) sawResp = 1'b1;
    end
    checkOutput("abort_no_resp", 32'(sawResp), 32'h0);
    refMem[5] = 32'h1234AABB;
    runModel(1'b1, 2'b10, 1'b0, 32'h14, 32'hCAFEF00D, "post_rst_sw");
    runModel(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, "post_rst_lw");

    for (int w = 0; w < 100; w++) begin
      runModel(1'b1, 2'b10, 1'b0, 32'(w) << 2, $urandom, "preload");
    end

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 15) == 0) a = $urandom;
      else a = (32'($urandom_range(0, 109)) << 2) | 32'($urandom_range(0, 3));
      runModel(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               a, $urandom, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
